// File: rtl/counter_cell_scheduler_pkg.sv
// Shared types and constants for the involuntary counter-cell scheduler.
package counter_cell_scheduler_pkg;

  localparam int CAD_W     = 6;
  localparam int IDX_W     = 5;
  localparam int NCELL_DEF = 29;

  localparam logic [CAD_W-1:0] BASE_ADDR_DEF = 6'o24;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GRANT,
    ST_RELEASE
  } state_e;

endpackage

// File: rtl/counter_prio_encoder.sv
// Combinational lowest-index-wins priority encoder over the valid pending cells.
module counter_prio_encoder
  import counter_cell_scheduler_pkg::*;
#(
  parameter int NCELL = NCELL_DEF
) (
  input  logic [NCELL-1:0] valid_i,
  output logic             found_o,
  output logic [IDX_W-1:0] idx_o
);

  // NOTE: every output gets a default before the loop, otherwise the
  // no-valid path would hold the old value and infer a latch.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    // Scan from the top down so the lowest set index is the last one written.
    for (int i = NCELL - 1; i >= 0; i--) begin
      if (valid_i[i]) begin
        found_o = 1'b1;
        idx_o   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/counter_cell_scheduler.sv
// Latches plus/minus counter-cell requests and grants one counter cycle at a time,
// lowest cell index first, at instruction-slot boundaries.
module counter_cell_scheduler
  import counter_cell_scheduler_pkg::*;
#(
  parameter int               NCELL     = NCELL_DEF,
  parameter logic [CAD_W-1:0] BASE_ADDR = BASE_ADDR_DEF
) (
  input  logic             CLOCK,
  input  logic             rst_n,
  input  logic             GOJAM,
  input  logic [NCELL-1:0] req_p,
  input  logic [NCELL-1:0] req_m,
  input  logic             slot_ok,
  input  logic             cyc_done,
  output logic             inkl,
  output logic [CAD_W-1:0] cad,
  output logic             inc_p,
  output logic             inc_m,
  output logic             ack,
  output logic [IDX_W-1:0] ack_idx
);

  if ((int'(BASE_ADDR) + NCELL - 1 > (1 << CAD_W) - 1) || (NCELL < 1) || (NCELL > (1 << IDX_W)))
  begin : g_bad_cfg
    $error("counter_cell_scheduler: cell range does not fit CAD/index width");
  end

  state_e           state_q;
  logic [IDX_W-1:0] idx_q;
  logic             plus_q;
  logic             inkl_q, inc_p_q, inc_m_q, ack_q;
  logic [CAD_W-1:0] cad_q;
  logic [IDX_W-1:0] ack_idx_q;

  logic [NCELL-1:0] pend_p_q, pend_p_d;
  logic [NCELL-1:0] pend_m_q, pend_m_d;
  logic [NCELL-1:0] svc_mask, cancel, clr_p, clr_m, valid;
  logic             win_found;
  logic [IDX_W-1:0] win_idx;

  assign valid = pend_p_q ^ pend_m_q;

  counter_prio_encoder #(.NCELL(NCELL)) u_prio (
    .valid_i (valid),
    .found_o (win_found),
    .idx_o   (win_idx)
  );

  // The cell under service is exempt from cancellation so an opposite-direction
  // request during its cycle is kept and serviced afterwards.
  assign svc_mask = (state_q != ST_IDLE) ? (NCELL'(1) << idx_q) : '0;
  assign cancel   = pend_p_q & pend_m_q & ~svc_mask;
  assign clr_p    = (state_q == ST_RELEASE &&  plus_q) ? svc_mask : '0;
  assign clr_m    = (state_q == ST_RELEASE && !plus_q) ? svc_mask : '0;

  always_comb begin
    pend_p_d = (pend_p_q & ~cancel & ~clr_p) | req_p;
    pend_m_d = (pend_m_q & ~cancel & ~clr_m) | req_m;
    if (GOJAM) begin
      pend_p_d = '0;
      pend_m_d = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLOCK or negedge rst_n) begin
    if (!rst_n) begin
      pend_p_q <= '0;
      pend_m_q <= '0;
    end else begin
      pend_p_q <= pend_p_d;
      pend_m_q <= pend_m_d;
    end
  end

  always_ff @(posedge CLOCK or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      plus_q    <= 1'b0;
      inkl_q    <= 1'b0;
      cad_q     <= '0;
      inc_p_q   <= 1'b0;
      inc_m_q   <= 1'b0;
      ack_q     <= 1'b0;
      ack_idx_q <= '0;
    end else if (GOJAM) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      plus_q    <= 1'b0;
      inkl_q    <= 1'b0;
      cad_q     <= '0;
      inc_p_q   <= 1'b0;
      inc_m_q   <= 1'b0;
      ack_q     <= 1'b0;
      ack_idx_q <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          ack_q <= 1'b0;
          if (slot_ok && win_found) begin
            state_q <= ST_GRANT;
            idx_q   <= win_idx;
            plus_q  <= pend_p_q[win_idx];
            inkl_q  <= 1'b1;
            cad_q   <= BASE_ADDR + CAD_W'(win_idx);
            inc_p_q <= pend_p_q[win_idx];
            inc_m_q <= pend_m_q[win_idx];
          end
        end
        ST_GRANT: begin
          if (cyc_done) begin
            state_q   <= ST_RELEASE;
            inkl_q    <= 1'b0;
            cad_q     <= '0;
            inc_p_q   <= 1'b0;
            inc_m_q   <= 1'b0;
            ack_q     <= 1'b1;
            ack_idx_q <= idx_q;
          end
        end
        ST_RELEASE: begin
          state_q <= ST_IDLE;
          ack_q   <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign inkl    = inkl_q;
  assign cad     = cad_q;
  assign inc_p   = inc_p_q;
  assign inc_m   = inc_m_q;
  assign ack     = ack_q;
  assign ack_idx = ack_idx_q;

endmodule
